// File: rtl/pim_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : pim_bus_responder
//  Brief    : Memory-mapped bus responder for a PIM compute core. Buffers
//             weight/activation writes in a write FIFO toward the core,
//             buffers core results in a result FIFO read back over the bus,
//             and exposes sticky status plus a compute start pulse.
//  Options  : PIM_RSP_PERF_EN - adds saturating push/pop counters readable
//             at PIM_CTRL | 4'h4 (reads 0 when undefined).
//  Revision : 1.0 - initial release
// ============================================================================
module pim_bus_responder #(
    parameter logic [31:0] PIM_CTRL         = 32'h4000_0010,
    parameter logic [31:0] PIM_R            = 32'h4000_0020,
    parameter logic [31:0] PIM_W_WEIGHT     = 32'h4000_0040,
    parameter logic [31:0] PIM_W_ACTIVATION = 32'h4000_0080,
    parameter int          FIFO_DEPTH       = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic        i_write,
    input  logic        i_read,
    input  logic [3:0]  i_size,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data,
    output logic        o_core_valid,
    input  logic        i_core_ready,
    output logic [31:0] o_core_data,
    output logic [3:0]  o_core_sel,
    output logic        o_core_act,
    input  logic        i_core_busy,
    input  logic        i_res_valid,
    input  logic [31:0] i_res_data,
    output logic        o_res_ready,
    output logic        o_start
);

    localparam int             c_AW    = $clog2(FIFO_DEPTH);
    localparam int             c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
    localparam logic [c_AW-1:0] c_PINC  = c_AW'(1);

    // Write FIFO: {act, sel[3:0], data[31:0]}
    logic [36:0]     r_wmem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wwp, r_wrp;
    logic [c_CW-1:0] r_wcnt;
    // Result FIFO
    logic [31:0]     r_rmem [FIFO_DEPTH];
    logic [c_AW-1:0] r_rwp, r_rrp;
    logic [c_CW-1:0] r_rcnt;

    logic        r_ovf, r_und, r_size_err;
    logic [31:0] r_rd_data;
    logic        r_start;
    logic [31:0] w_rd_next;

    // Address decode on bits [31:4]; low nibble is the PIM select / offset
    logic w_hit_ctrl, w_hit_r, w_hit_w, w_hit_a;
    assign w_hit_ctrl = (i_addr[31:4] == PIM_CTRL[31:4]);
    assign w_hit_r    = (i_addr[31:4] == PIM_R[31:4]);
    assign w_hit_w    = (i_addr[31:4] == PIM_W_WEIGHT[31:4]);
    assign w_hit_a    = (i_addr[31:4] == PIM_W_ACTIVATION[31:4]);

    // A simultaneous read and write behaves as a write only
    logic w_rd_acc;
    assign w_rd_acc = i_read && !i_write;

    logic w_ctrl_wr, w_flush, w_start;
    assign w_ctrl_wr = i_write && w_hit_ctrl && i_size[0];
    assign w_flush   = w_ctrl_wr && i_wr_data[3];
    assign w_start   = w_ctrl_wr && i_wr_data[2];

    logic w_data_wr, w_push_req, w_size_bad;
    assign w_data_wr  = i_write && (w_hit_w || w_hit_a);
    assign w_push_req = w_data_wr && (i_size == 4'hF);
    assign w_size_bad = w_data_wr && (i_size != 4'hF);

    logic w_wfull, w_wempty, w_wpop, w_wpush, w_wovf;
    assign w_wfull  = (r_wcnt == c_DEPTH);
    assign w_wempty = (r_wcnt == '0);
    assign w_wpop   = !w_wempty && i_core_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wpush  = w_push_req && (!w_wfull || w_wpop);
    assign w_wovf   = w_push_req && w_wfull && !w_wpop;

    logic w_rfull, w_rempty, w_rd_r, w_rpop, w_rund, w_rpush;
    assign w_rfull  = (r_rcnt == c_DEPTH);
    assign w_rempty = (r_rcnt == '0);
    assign w_rd_r   = w_rd_acc && w_hit_r;
    assign w_rpop   = w_rd_r && !w_rempty;
    assign w_rund   = w_rd_r && w_rempty;
    assign o_res_ready = !w_rfull || w_rpop;
    assign w_rpush  = i_res_valid && o_res_ready;

    assign o_core_valid = !w_wempty;
    assign {o_core_act, o_core_sel, o_core_data} = r_wmem[r_wrp];
    assign o_rd_data = r_rd_data;
    assign o_start   = r_start;

`ifdef PIM_RSP_PERF_EN
    logic [15:0] r_wr_cnt, r_rd_cnt;

    // Saturating counters of accepted data pushes and result pops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (w_flush) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wpush && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_rpop  && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
        end
    end
`endif

    // Read data mux: status, perf counters, result head or zero
    always_comb begin
        w_rd_next = 32'd0;
        if (w_hit_ctrl) begin
            if (i_addr[3:0] == 4'h0) begin
                w_rd_next = {25'd0, r_size_err, r_und, r_ovf, 2'b00,
                             !w_rempty, (w_wfull || i_core_busy)};
            end else if (i_addr[3:0] == 4'h4) begin
`ifdef PIM_RSP_PERF_EN
                w_rd_next = {r_rd_cnt, r_wr_cnt};
`else
                w_rd_next = 32'd0;
`endif
            end
        end else if (w_hit_r && !w_rempty) begin
            w_rd_next = r_rmem[r_rrp];
        end
    end

    // Write FIFO storage (contents need no reset; pointers gate validity)
    always_ff @(posedge i_clk) begin
        if (w_wpush && !w_flush) r_wmem[r_wwp] <= {w_hit_a, i_addr[3:0], i_wr_data};
        if (w_rpush && !w_flush) r_rmem[r_rwp] <= i_res_data;
    end

    // FIFO pointers and occupancy; flush overrides every push and pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wwp <= '0; r_wrp <= '0; r_wcnt <= '0;
            r_rwp <= '0; r_rrp <= '0; r_rcnt <= '0;
        end else if (w_flush) begin
            r_wwp <= '0; r_wrp <= '0; r_wcnt <= '0;
            r_rwp <= '0; r_rrp <= '0; r_rcnt <= '0;
        end else begin
            if (w_wpush) r_wwp <= r_wwp + c_PINC;
            if (w_wpop)  r_wrp <= r_wrp + c_PINC;
            if (w_wpush && !w_wpop)      r_wcnt <= r_wcnt + c_ONE;
            else if (!w_wpush && w_wpop) r_wcnt <= r_wcnt - c_ONE;
            if (w_rpush) r_rwp <= r_rwp + c_PINC;
            if (w_rpop)  r_rrp <= r_rrp + c_PINC;
            if (w_rpush && !w_rpop)      r_rcnt <= r_rcnt + c_ONE;
            else if (!w_rpush && w_rpop) r_rcnt <= r_rcnt - c_ONE;
        end
    end

    // Sticky error flags, registered read data and start pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf      <= 1'b0;
            r_und      <= 1'b0;
            r_size_err <= 1'b0;
            r_rd_data  <= 32'd0;
            r_start    <= 1'b0;
        end else begin
            r_start <= w_start;
            if (w_rd_acc) r_rd_data <= w_rd_next;
            if (w_flush) begin
                r_ovf      <= 1'b0;
                r_und      <= 1'b0;
                r_size_err <= 1'b0;
            end else begin
                if (w_wovf)     r_ovf      <= 1'b1;
                if (w_rund)     r_und      <= 1'b1;
                if (w_size_bad) r_size_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pim_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pim_bus_responder
//  Brief    : Scoreboard bench for pim_bus_responder. Stimulus pushes
//             expected read data / core entries into queues; a monitor on
//             the falling edge pops and compares whenever the DUT presents
//             read data or completes a core handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pim_bus_responder;

    localparam logic [31:0] c_CTRL = 32'h4000_0010;
    localparam logic [31:0] c_R    = 32'h4000_0020;
    localparam logic [31:0] c_WW   = 32'h4000_0040;
    localparam logic [31:0] c_WA   = 32'h4000_0080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        write, read;
    logic [3:0]  size;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        core_valid, core_ready, core_act, core_busy;
    logic [31:0] core_data;
    logic [3:0]  core_sel;
    logic        res_valid, res_ready, start;
    logic [31:0] res_data;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rd_q [$];
    logic [36:0] core_q [$];
    logic        rd_pend = 1'b0;

    always #5 clk = ~clk;

    pim_bus_responder dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_write(write),
        .i_read(read), .i_size(size), .i_wr_data(wr_data), .o_rd_data(rd_data),
        .o_core_valid(core_valid), .i_core_ready(core_ready),
        .o_core_data(core_data), .o_core_sel(core_sel), .o_core_act(core_act),
        .i_core_busy(core_busy), .i_res_valid(res_valid), .i_res_data(res_data),
        .o_res_ready(res_ready), .o_start(start)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare registered read data and core handshakes
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 64'(rd_data), 64'hDEAD_0000_0000);
            else chk("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
        end
        rd_pend = rst_n && read && !write;
        if (rst_n && core_valid && core_ready) begin
            if (core_q.size() == 0)
                chk("core_unexpected", 64'({core_act, core_sel, core_data}), 64'hDEAD_0000_0000);
            else
                chk("core_head", 64'({core_act, core_sel, core_data}), 64'(core_q.pop_front()));
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        addr = a; wr_data = d; size = s; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; size = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        addr = a; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic res_push(input logic [31:0] d);
        res_valid = 1'b1; res_data = d;
        @(posedge clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; write = 0; read = 0; size = '0; wr_data = '0;
        core_ready = 0; core_busy = 0; res_valid = 0; res_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_valid", 64'(core_valid), 64'd0);
        chk("rst_res_ready", 64'(res_ready), 64'd1);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Single weight write with core ready
        core_q.push_back({1'b0, 4'h3, 32'h11});
        core_ready = 1'b1;
        bus_write(32'h4000_0043, 32'h11, 4'hF);
        idle(3);
        core_ready = 1'b0;
        bus_read(c_CTRL, 32'h0);

        // Partial byte-enable write is dropped and flagged
        bus_write(32'h4000_0041, 32'h22, 4'b0011);
        chk("size_err_no_push", 64'(core_valid), 64'd0);
        bus_read(c_CTRL, 32'h40);
        // Simultaneous write+read: treated as write, read data held
        addr = c_CTRL; wr_data = 32'h0; size = 4'h0; write = 1'b1; read = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        chk("wr_rd_hold", 64'(rd_data), 64'h40);
        bus_write(c_CTRL, 32'h8, 4'h1);
        bus_read(c_CTRL, 32'h0);

        // Overflow: five activation writes into a depth-4 FIFO
        for (int i = 0; i < 5; i++) bus_write(c_WA, 32'hA0 + i, 4'hF);
        bus_read(c_CTRL, 32'h11);
        for (int i = 0; i < 4; i++) core_q.push_back({1'b1, 4'h0, 32'hA0 + i});
        core_ready = 1'b1;
        idle(6);
        core_ready = 1'b0;
        bus_read(c_CTRL, 32'h10);
        bus_write(c_CTRL, 32'h8, 4'h1);

        // Full FIFO accepts a push when the core pops in the same cycle
        for (int i = 0; i < 4; i++) bus_write(32'h4000_0045, 32'hB0 + i, 4'hF);
        for (int i = 0; i < 5; i++) core_q.push_back({1'b0, 4'h5, 32'hB0 + i});
        core_ready = 1'b1;
        bus_write(32'h4000_0045, 32'hB4, 4'hF);
        idle(6);
        core_ready = 1'b0;
        bus_read(c_CTRL, 32'h0);

        // Result FIFO ordering and underflow
        res_push(32'hA);
        res_push(32'hB);
        bus_read(c_CTRL, 32'h2);
        bus_read(c_R, 32'hA);
        bus_read(c_R, 32'hB);
        bus_read(c_R, 32'h0);
        bus_read(c_CTRL, 32'h20);
        bus_write(c_CTRL, 32'h8, 4'h1);

        // Result FIFO full, then simultaneous pop and push
        for (int i = 0; i < 4; i++) res_push(32'h101 + i);
        @(negedge clk);
        chk("res_full_ready", 64'(res_ready), 64'd0);
        @(posedge clk); #1;
        rd_q.push_back(32'h101);
        addr = c_R; read = 1'b1; res_valid = 1'b1; res_data = 32'h55;
        @(negedge clk);
        chk("res_ready_pop", 64'(res_ready), 64'd1);
        @(posedge clk); #1;
        read = 1'b0; res_valid = 1'b0;
        bus_read(c_R, 32'h102);
        bus_read(c_R, 32'h103);
        bus_read(c_R, 32'h104);
        bus_read(c_R, 32'h55);
        bus_read(c_CTRL, 32'h0);

        // Flush with both FIFOs non-empty
        bus_write(c_WW, 32'h1, 4'hF);
        bus_write(c_WW, 32'h2, 4'hF);
        res_push(32'h9);
        bus_write(c_CTRL, 32'h8, 4'h1);
        chk("flush_core_valid", 64'(core_valid), 64'd0);
        bus_read(c_CTRL, 32'h0);
        bus_read(c_R, 32'h0);
        bus_write(c_CTRL, 32'h8, 4'h1);

        // Start pulse lasts exactly one cycle
        chk("start_idle", 64'(start), 64'd0);
        bus_write(c_CTRL, 32'h4, 4'h1);
        chk("start_high", 64'(start), 64'd1);
        idle(1);
        chk("start_low", 64'(start), 64'd0);

        // Perf/offset window and unmapped read
        bus_write(c_WW, 32'h7, 4'hF);
        res_push(32'h77);
        bus_read(c_R, 32'h77);
`ifdef PIM_RSP_PERF_EN
        bus_read(c_CTRL | 32'h4, 32'h0001_0001);
`else
        bus_read(c_CTRL | 32'h4, 32'h0);
`endif
        bus_read(32'h4000_0100, 32'h0);
        core_busy = 1'b1;
        bus_read(c_CTRL, 32'h1);
        core_busy = 1'b0;
        bus_write(c_CTRL, 32'h8, 4'h1);

        // Reset mid-transfer discards buffered entries
        bus_write(c_WA, 32'hC1, 4'hF);
        bus_write(c_WA, 32'hC2, 4'hF);
        res_push(32'hC3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_core_valid", 64'(core_valid), 64'd0);
        chk("rst_mid_res_ready", 64'(res_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        bus_read(c_CTRL, 32'h0);
        bus_read(c_R, 32'h0);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && (rd_q.size() != 0 || core_q.size() != 0); i++) idle(1);
        idle(2);
        chk("scoreboard_rd_left", 64'(rd_q.size()), 64'd0);
        chk("scoreboard_core_left", 64'(core_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
